uart_frame_parser: RTL and testbench

//   Parametrised byte-stream frame parser behind the UART receiver, feeding the FIFO controller.

---
 rtl/uart_frame_parser.sv | 179 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: splits the UART byte stream into command, length and payload.
// Frame: cmd byte, LEN_BYTES length bytes (MSB first), then <length> payload bytes.
// The parser holds busy after the frame until the FIFO side reports fifo_done.
// All outputs are registered and respond the cycle after the triggering byte strobe.
module uart_frame_parser #(
    parameter int unsigned LEN_BYTES   = 2,
    parameter int unsigned CNT_W       = 8 * LEN_BYTES,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rok,
    input  logic [7:0]       i_mosi,
    input  logic             i_fifo_done,
    output logic [7:0]       o_cmd,
    output logic [CNT_W-1:0] o_rx_cnt,
    output logic             o_hdr_valid,
    output logic             o_pay_valid,
    output logic [7:0]       o_pay_data,
    output logic             o_pay_last,
    output logic             o_busy,
    output logic             o_err_timeout,
    output logic             o_err_ovf
);

    localparam int unsigned IDX_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN_BYTES - 1);
    // Idle count value that triggers the timeout on the following silent cycle.
    localparam logic [TO_W-1:0]  TO_LAST  = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLen,
        StPayload,
        StWaitDone
    } state_e;

    state_e           r_state;
    logic [IDX_W-1:0] r_len_idx;
    logic [CNT_W-1:0] r_remain;
    logic [TO_W-1:0]  r_idle_cnt;

    logic [7:0]       r_cmd;
    logic [CNT_W-1:0] r_rx_cnt;
    logic             r_hdr_valid;
    logic             r_pay_valid;
    logic [7:0]       r_pay_data;
    logic             r_pay_last;
    logic             r_busy;
    logic             r_err_timeout;
    logic             r_err_ovf;

    logic [CNT_W-1:0] w_len_next;
    logic             w_len_last;
    logic             w_timeout;

    // Length shift register: append the new byte, keep the low CNT_W bits.
    generate
        if (CNT_W > 8) begin : g_len_wide
            assign w_len_next = {r_rx_cnt[CNT_W-9:0], i_mosi};
        end else begin : g_len_narrow
            assign w_len_next = i_mosi[CNT_W-1:0];
        end
    endgenerate

    assign w_len_last = (r_len_idx == IDX_LAST);
    assign w_timeout  = (TIMEOUT_CYC != 0) && (r_idle_cnt == TO_LAST);

    // Frame FSM with registered outputs; fifo_done outranks rok, rok outranks timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_len_idx     <= '0;
            r_remain      <= '0;
            r_idle_cnt    <= '0;
            r_cmd         <= '0;
            r_rx_cnt      <= '0;
            r_hdr_valid   <= 1'b0;
            r_pay_valid   <= 1'b0;
            r_pay_data    <= '0;
            r_pay_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_hdr_valid   <= 1'b0;
            r_pay_valid   <= 1'b0;
            r_pay_last    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_ovf     <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (i_rok) begin
                        r_cmd      <= i_mosi;
                        r_rx_cnt   <= '0;
                        r_len_idx  <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= StLen;
                    end
                end

                StLen: begin
                    if (i_fifo_done) begin
                        r_state <= StIdle;
                    end else if (i_rok) begin
                        r_idle_cnt <= '0;
                        r_rx_cnt   <= w_len_next;
                        r_len_idx  <= r_len_idx + 1'b1;
                        if (w_len_last) begin
                            r_hdr_valid <= 1'b1;
                            if (w_len_next == '0) begin
                                r_busy  <= 1'b1;
                                r_state <= StWaitDone;
                            end else begin
                                r_remain <= w_len_next;
                                r_state  <= StPayload;
                            end
                        end
                    end else if (w_timeout) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= StIdle;
                    end else if (TIMEOUT_CYC != 0) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end

                StPayload: begin
                    if (i_fifo_done) begin
                        r_state <= StIdle;
                    end else if (i_rok) begin
                        r_idle_cnt  <= '0;
                        r_pay_valid <= 1'b1;
                        r_pay_data  <= i_mosi;
                        r_remain    <= r_remain - 1'b1;
                        if (r_remain == REM_ONE) begin
                            r_pay_last <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= StWaitDone;
                        end
                    end else if (w_timeout) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= StIdle;
                    end else if (TIMEOUT_CYC != 0) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end

                StWaitDone: begin
                    if (i_fifo_done) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (i_rok) begin
                        // Downstream still owns the previous frame: drop and flag.
                        r_err_ovf <= 1'b1;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd         = r_cmd;
    assign o_rx_cnt      = r_rx_cnt;
    assign o_hdr_valid   = r_hdr_valid;
    assign o_pay_valid   = r_pay_valid;
    assign o_pay_data    = r_pay_data;
    assign o_pay_last    = r_pay_last;
    assign o_busy        = r_busy;
    assign o_err_timeout = r_err_timeout;
    assign o_err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: scoreboarded main instance (2 length bytes, timeout 16)
// plus 1- and 4-length-byte instances checked directly.
module tb_uart_frame_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: LEN_BYTES=2, TIMEOUT_CYC=16
    logic        rst0 = 1'b1, rok0 = 1'b0, done0 = 1'b0;
    logic [7:0]  mosi0 = '0;
    logic [7:0]  cmd0, pdata0;
    logic [15:0] rx0;
    logic        hdr0, pay0, last0, busy0, to0, ovf0;

    // Instance 1: LEN_BYTES=1
    logic        rst1 = 1'b1, rok1 = 1'b0, done1 = 1'b0;
    logic [7:0]  mosi1 = '0;
    logic [7:0]  cmd1, pdata1;
    logic [7:0]  rx1;
    logic        hdr1, pay1, last1, busy1, to1, ovf1;

    // Instance 2: LEN_BYTES=4
    logic        rst2 = 1'b1, rok2 = 1'b0, done2 = 1'b0;
    logic [7:0]  mosi2 = '0;
    logic [7:0]  cmd2, pdata2;
    logic [31:0] rx2;
    logic        hdr2, pay2, last2, busy2, to2, ovf2;

    uart_frame_parser #(.LEN_BYTES(2), .TIMEOUT_CYC(16)) u_dut0 (
        .i_clk(clk), .i_rst(rst0), .i_rok(rok0), .i_mosi(mosi0), .i_fifo_done(done0),
        .o_cmd(cmd0), .o_rx_cnt(rx0), .o_hdr_valid(hdr0), .o_pay_valid(pay0),
        .o_pay_data(pdata0), .o_pay_last(last0), .o_busy(busy0),
        .o_err_timeout(to0), .o_err_ovf(ovf0)
    );

    uart_frame_parser #(.LEN_BYTES(1), .TIMEOUT_CYC(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_rok(rok1), .i_mosi(mosi1), .i_fifo_done(done1),
        .o_cmd(cmd1), .o_rx_cnt(rx1), .o_hdr_valid(hdr1), .o_pay_valid(pay1),
        .o_pay_data(pdata1), .o_pay_last(last1), .o_busy(busy1),
        .o_err_timeout(to1), .o_err_ovf(ovf1)
    );

    uart_frame_parser #(.LEN_BYTES(4), .TIMEOUT_CYC(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_rok(rok2), .i_mosi(mosi2), .i_fifo_done(done2),
        .o_cmd(cmd2), .o_rx_cnt(rx2), .o_hdr_valid(hdr2), .o_pay_valid(pay2),
        .o_pay_data(pdata2), .o_pay_last(last2), .o_busy(busy2),
        .o_err_timeout(to2), .o_err_ovf(ovf2)
    );

    localparam logic [3:0] EvHdr = 4'd1, EvPay = 4'd2, EvTo = 4'd3, EvOvf = 4'd4;

    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_evt(input logic [3:0] kind, input logic [7:0] a,
                                            input logic [15:0] b, input logic last);
        return {35'd0, kind, a, b, last};
    endfunction

    task automatic sb_pop(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_unexpected"}, obs, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for instance 0, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst0) begin
            if (hdr0) sb_pop("hdr", mk_evt(EvHdr, cmd0, rx0, 1'b0));
            if (pay0) sb_pop("pay", mk_evt(EvPay, pdata0, 16'd0, last0));
            if (to0)  sb_pop("timeout", mk_evt(EvTo, 8'd0, 16'd0, 1'b0));
            if (ovf0) sb_pop("ovf", mk_evt(EvOvf, 8'd0, 16'd0, 1'b0));
        end
    end

    // Present one byte for one cycle; returns at the negedge where its response is visible.
    task automatic send(input int tgt, input logic [7:0] b);
        case (tgt)
            0: begin rok0 = 1'b1; mosi0 = b; end
            1: begin rok1 = 1'b1; mosi1 = b; end
            default: begin rok2 = 1'b1; mosi2 = b; end
        endcase
        @(negedge clk);
        rok0 = 1'b0;
        rok1 = 1'b0;
        rok2 = 1'b0;
    endtask

    task automatic pulse_done0();
        done0 = 1'b1;
        @(negedge clk);
        done0 = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cmd", {56'd0, cmd0}, 64'h00);
        check("rst_rx_cnt", {48'd0, rx0}, 64'h0);
        check("rst_flags", {58'd0, hdr0, pay0, last0, busy0, to0, ovf0}, 64'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);

        // Basic frame with three payload bytes
        sb_q.push_back(mk_evt(EvHdr, 8'hA5, 16'h0003, 1'b0));
        sb_q.push_back(mk_evt(EvPay, 8'h11, 16'd0, 1'b0));
        sb_q.push_back(mk_evt(EvPay, 8'h22, 16'd0, 1'b0));
        sb_q.push_back(mk_evt(EvPay, 8'h33, 16'd0, 1'b1));
        send(0, 8'hA5);
        send(0, 8'h00);
        send(0, 8'h03);
        send(0, 8'h11);
        send(0, 8'h22);
        send(0, 8'h33);
        check("t1_busy", {63'd0, busy0}, 64'd1);
        check("t1_cmd", {56'd0, cmd0}, 64'hA5);
        check("t1_rx_cnt", {48'd0, rx0}, 64'h3);
        repeat (3) @(negedge clk);
        check("t1_busy_hold", {63'd0, busy0}, 64'd1);
        pulse_done0();
        check("t1_busy_clear", {63'd0, busy0}, 64'd0);

        // fifo_done while idle changes nothing
        pulse_done0();
        check("idle_done_cmd", {56'd0, cmd0}, 64'hA5);
        check("idle_done_busy", {63'd0, busy0}, 64'd0);

        // Zero-length frame, then a byte while busy
        sb_q.push_back(mk_evt(EvHdr, 8'h7E, 16'h0000, 1'b0));
        send(0, 8'h7E);
        send(0, 8'h00);
        send(0, 8'h00);
        check("t2_busy", {63'd0, busy0}, 64'd1);
        sb_q.push_back(mk_evt(EvOvf, 8'd0, 16'd0, 1'b0));
        send(0, 8'h55);
        check("t4_busy", {63'd0, busy0}, 64'd1);
        check("t4_cmd", {56'd0, cmd0}, 64'h7E);
        check("t4_rx_cnt", {48'd0, rx0}, 64'h0);
        pulse_done0();
        check("t2_busy_clear", {63'd0, busy0}, 64'd0);

        // Timeout after a partial header
        sb_q.push_back(mk_evt(EvTo, 8'd0, 16'd0, 1'b0));
        send(0, 8'hC3);
        send(0, 8'h07);
        repeat (15) @(negedge clk);
        check("t3_no_early_to", {63'd0, to0}, 64'd0);
        @(negedge clk);
        check("t3_to_cycle16", {63'd0, to0}, 64'd1);
        check("t3_partial_cmd", {56'd0, cmd0}, 64'hC3);
        check("t3_partial_len", {48'd0, rx0}, 64'h0007);
        send(0, 8'h42);
        check("t3_new_cmd", {56'd0, cmd0}, 64'h42);
        check("t3_len_cleared", {48'd0, rx0}, 64'h0);
        sb_q.push_back(mk_evt(EvHdr, 8'h42, 16'h0001, 1'b0));
        sb_q.push_back(mk_evt(EvPay, 8'h99, 16'd0, 1'b1));
        send(0, 8'h00);
        send(0, 8'h01);
        send(0, 8'h99);
        pulse_done0();

        // fifo_done coincident with second payload byte
        sb_q.push_back(mk_evt(EvHdr, 8'h5A, 16'h0002, 1'b0));
        sb_q.push_back(mk_evt(EvPay, 8'h01, 16'd0, 1'b0));
        send(0, 8'h5A);
        send(0, 8'h00);
        send(0, 8'h02);
        send(0, 8'h01);
        rok0 = 1'b1;
        mosi0 = 8'h02;
        done0 = 1'b1;
        @(negedge clk);
        rok0 = 1'b0;
        done0 = 1'b0;
        check("t5_busy", {63'd0, busy0}, 64'd0);
        repeat (2) @(negedge clk);
        check("t5_busy_stays", {63'd0, busy0}, 64'd0);
        sb_q.push_back(mk_evt(EvHdr, 8'h11, 16'h0001, 1'b0));
        sb_q.push_back(mk_evt(EvPay, 8'hAB, 16'd0, 1'b1));
        send(0, 8'h11);
        send(0, 8'h00);
        send(0, 8'h01);
        send(0, 8'hAB);
        check("t5_next_busy", {63'd0, busy0}, 64'd1);
        pulse_done0();

        // One length byte
        send(1, 8'h3C);
        check("lb1_no_hdr_yet", {63'd0, hdr1}, 64'd0);
        send(1, 8'h02);
        check("lb1_hdr", {63'd0, hdr1}, 64'd1);
        check("lb1_rx_cnt", {56'd0, rx1}, 64'h02);
        send(1, 8'hD1);
        check("lb1_pay0", {54'd0, pay1, last1, pdata1}, {54'd0, 2'b10, 8'hD1});
        send(1, 8'hD2);
        check("lb1_pay1", {54'd0, pay1, last1, pdata1}, {54'd0, 2'b11, 8'hD2});
        check("lb1_busy", {63'd0, busy1}, 64'd1);

        // Four length bytes, then reset in the middle of the payload
        send(2, 8'h3C);
        send(2, 8'h00);
        send(2, 8'h00);
        send(2, 8'h00);
        check("lb4_no_hdr_yet", {63'd0, hdr2}, 64'd0);
        send(2, 8'h02);
        check("lb4_hdr", {63'd0, hdr2}, 64'd1);
        check("lb4_rx_cnt", {32'd0, rx2}, 64'h0000_0002);
        send(2, 8'hE1);
        check("lb4_pay0", {54'd0, pay2, last2, pdata2}, {54'd0, 2'b10, 8'hE1});
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        check("lb4_rst_regs", {24'd0, cmd2, rx2}, 64'd0);
        check("lb4_rst_flags", {50'd0, pdata2, hdr2, pay2, last2, busy2, to2, ovf2}, 64'd0);
        send(2, 8'hE2);
        check("lb4_rst_idle", {23'd0, pay2, cmd2, rx2}, {23'd0, 1'b0, 8'hE2, 32'd0});

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
